alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU, the next generation of the processor's combinational 16-bit ALU.
- Adds iterative multiply and divide, shifts, signed compare, and a registered result and flag set with a valid/ready handshake.
- Sits in the execute stage of the multi-cycle datapath. The control FSM issues one operation and waits for out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request (high only in IDLE).
- op  in  4  operation code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  one-cycle pulse: result and flags updated.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD carry-out; SUB/SLT: 1 when a >= b unsigned (no borrow).
- overflow  out  1  signed overflow for ADD/SUB; else 0.
- div_by_zero  out  1  set by DIVU/REMU with b == 0; else 0.

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; negative=0; carry=0; overflow=0; div_by_zero=0.
  - Reset overrides flush and in_valid.
- Opcodes:
  - 0 AND, 1 ADD, 2 SUB, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = b[CNT_W-2:0]; amounts >= WIDTH are not possible by construction.
  - 8 MUL: low WIDTH bits of the unsigned product.
  - 9 MULHU: high WIDTH bits of the unsigned product.
  - 10 DIVU: quotient. 11 REMU: remainder.
  - 12 PASSA, 13 PASSB.
  - 14 SLT: signed a<b gives 1, else 0.
  - 15 reserved: result 0.
- States: IDLE, ITER. Accept = in_valid & in_ready.
- Single-cycle ops (0-7, 12-15):
  - Accepted at edge k; result, flags and out_valid=1 are registered at the same edge k.
  - Visible the cycle after acceptance: latency 1.
  - Back-to-back acceptance is allowed every cycle.
- Iterative ops (8-11):
  - At accept, go IDLE->ITER; latch a and b; counter=WIDTH.
  - One shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements.
  - When counter reaches 1, that edge writes result and flags, pulses out_valid, and returns to IDLE.
  - Accept at edge k gives out_valid in the cycle after edge k+WIDTH-1, i.e. latency WIDTH cycles. in_ready=0 throughout ITER.
- Divide by zero:
  - Single-cycle completion (latency 1, no ITER).
  - DIVU result = all ones; REMU result = a; div_by_zero=1.
- Flags:
  - zero and negative are always derived from the new result.
  - carry and overflow are 0 for ops other than ADD/SUB/SLT.
  - All flags hold their values between completions.
- out_valid: high exactly one cycle per completed operation; there is no output backpressure.
- flush:
  - In ITER: return to IDLE at that edge. No out_valid; result and flags unchanged.
  - In IDLE: suppresses acceptance in that cycle.
- Operands a, b and op may change freely after acceptance; the latched copies are used.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 16 opcodes;
  - state encodings IDLE/ITER;
  - an is_iterative(op) function.
- One natural sub-module, alu_iter_unit: a WIDTH-parameterised shift-add multiplier and restoring divider sharing the accumulator, counter and shift register, with start/done ports.

Test Plan (WIDTH=16):
1. Reset and ADD:
   - Stimulus: hold rst_n=0 for 2 cycles, then ADD a=16'hFFFF, b=16'h0001.
   - Response: after reset, all outputs are at reset values. Next cycle: result=0, zero=1, carry=1, overflow=0, out_valid=1 for one cycle.
2. SUB overflow:
   - Stimulus: SUB a=16'h8000, b=16'h0001.
   - Response: result=16'h7FFF, overflow=1, negative=0, carry=1.
   - Follow-up: SLT a=16'hFFFE, b=16'h0001 gives result=1.
3. MUL/MULHU latency:
   - Stimulus: MUL a=300, b=300.
   - Response: in_ready low 16 cycles; out_valid 16 cycles after accept; result=16'h5F90. MULHU on the same operands gives result=16'h0001.
4. DIVU/REMU:
   - Stimulus: a=1000, b=7.
   - Response: DIVU gives 142, REMU gives 6, each with latency 16.
   - Follow-up: DIVU a=5, b=0 gives result=16'hFFFF, div_by_zero=1, latency 1.
5. Flush mid-MUL:
   - Stimulus: assert flush at iteration 5 of a MUL.
   - Response: no out_valid; result and flags unchanged; in_ready=1 the next cycle. An immediate ADD 2+3 completes with result=5.
6. Reset mid-DIVU:
   - Stimulus: drive rst_n=0 during DIVU iteration 8.
   - Response: all outputs return to reset values; no out_valid is emitted afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification for the
// multi-cycle ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;
  localparam logic [3:0] OP_PASSA = 4'd12;
  localparam logic [3:0] OP_PASSB = 4'd13;
  localparam logic [3:0] OP_SLT   = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shift-add multiplier and restoring divider sharing one accumulator, one
// shift register and one step counter. The first step runs on the accept edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic             sel_div,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, sh_q, opnd_q;
  logic             div_q, hi_q;

  logic [WIDTH-1:0] cur_acc, cur_sh, cur_opnd;
  logic             cur_div, cur_hi;
  logic [WIDTH-1:0] acc_d, sh_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign cur_acc  = start ? '0      : acc_q;
  assign cur_sh   = start ? a       : sh_q;
  assign cur_opnd = start ? b       : opnd_q;
  assign cur_div  = start ? sel_div : div_q;
  assign cur_hi   = start ? sel_hi  : hi_q;

  // MUL: {acc, sh} holds {partial high, multiplier/product low}, shifted right.
  // DIV: {acc, sh} holds {partial remainder, dividend/quotient}, shifted left.
  assign mul_sum   = {1'b0, cur_acc} + (cur_sh[0] ? {1'b0, cur_opnd} : '0);
  assign div_shift = {cur_acc, cur_sh[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, cur_opnd};
  assign div_diff  = div_shift[WIDTH-1:0] - cur_opnd;

  always_comb begin
    acc_d = mul_sum[WIDTH:1];
    sh_d  = {mul_sum[0], cur_sh[WIDTH-1:1]};
    if (cur_div) begin
      acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      sh_d  = {cur_sh[WIDTH-2:0], div_ge};
    end
  end

  assign res  = cur_hi ? acc_d : sh_d;
  assign done = (cnt_q == CNT_W'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CNT_W'(WIDTH);
    end else if (flush || done) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start || (cnt_q != '0)) begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= cur_opnd;
      div_q  <= cur_div;
      hi_q   <= cur_hi;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// multiply/divide, with a registered result, flags and a one-cycle out_valid.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, negative_q, carry_q, overflow_q, dbz_q;

  logic                    accept, div0, start_iter;
  logic                    iter_done;
  logic [WIDTH-1:0]        iter_res;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          add_sum, sub_diff;
  logic [CNT_W-2:0]        shamt;
  logic [WIDTH-1:0]        res_d;
  logic                    carry_d, overflow_d, dbz_d;

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready && !flush;
  assign div0       = ((op == OP_DIVU) || (op == OP_REMU)) && (b == '0);
  assign start_iter = accept && is_iterative(op) && !div0;

  assign a_s      = a;
  assign b_s      = b;
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign shamt    = b[CNT_W-2:0];

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  always_comb begin
    res_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    dbz_d      = 1'b0;
    case (op)
      OP_AND:   res_d = a & b;
      OP_OR:    res_d = a | b;
      OP_XOR:   res_d = a ^ b;
      OP_ADD: begin
        res_d      = add_sum[WIDTH-1:0];
        carry_d    = add_sum[WIDTH];
        overflow_d = add_ovf(a[WIDTH-1], b[WIDTH-1], add_sum[WIDTH-1]);
      end
      OP_SUB: begin
        res_d      = sub_diff[WIDTH-1:0];
        carry_d    = !sub_diff[WIDTH];
        overflow_d = add_ovf(a[WIDTH-1], !b[WIDTH-1], sub_diff[WIDTH-1]);
      end
      OP_SLT: begin
        res_d   = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
        carry_d = !sub_diff[WIDTH];
      end
      OP_SLL:   res_d = a << shamt;
      OP_SRL:   res_d = a >> shamt;
      OP_SRA:   res_d = a_s >>> shamt;
      OP_PASSA: res_d = a;
      OP_PASSB: res_d = b;
      // Only reached here with b == 0; non-zero divisors go to the iterative unit.
      OP_DIVU: begin
        res_d = '1;
        dbz_d = 1'b1;
      end
      OP_REMU: begin
        res_d = a;
        dbz_d = 1'b1;
      end
      default:  res_d = '0;
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .start   (start_iter),
    .sel_div (op[1]),
    .sel_hi  (op[0]),
    .a       (a),
    .b       (b),
    .done    (iter_done),
    .res     (iter_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_iter) begin
            state_q <= ITER;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            zero_q      <= (res_d == '0);
            negative_q  <= res_d[WIDTH-1];
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
          end
        end
        ITER: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (iter_done) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
            negative_q  <= iter_res[WIDTH-1];
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign negative    = negative_q;
  assign carry       = carry_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=16): hand-computed results, flags and latencies.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [3:0]  op;
  logic [15:0] a, b, result;
  logic        out_valid, zero, negative, carry, overflow, div_by_zero;

  int n_pass = 0;
  int n_chk  = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Packed view: {out_valid, zero, negative, carry, overflow, div_by_zero, result}
  function automatic logic [31:0] pk(input logic v, z, n, c, o, d, input logic [15:0] r);
    return {10'b0, v, z, n, c, o, d, r};
  endfunction

  function automatic logic [31:0] obs();
    return pk(out_valid, zero, negative, carry, overflow, div_by_zero, result);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble the operand inputs after acceptance, and count the
  // cycles up to the out_valid pulse (bounded at 40).
  task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        output int latency);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op = 4'h0; a = 16'hDEAD; b = 16'hBEEF;
    latency = 1;
    while (!out_valid && latency < 40) begin
      chk("ready_low_busy", {31'b0, in_ready}, 32'd0);
      tick();
      latency++;
    end
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [15:0] x, y;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'd0,  16'hF0F0, 16'h3C3C, pk(1,0,0,0,0,0,16'h3030)};
    tbl[1]  = '{4'd3,  16'hF0F0, 16'h3C3C, pk(1,0,1,0,0,0,16'hFCFC)};
    tbl[2]  = '{4'd4,  16'hF0F0, 16'h3C3C, pk(1,0,1,0,0,0,16'hCCCC)};
    tbl[3]  = '{4'd5,  16'h0001, 16'h0014, pk(1,0,0,0,0,0,16'h0010)};
    tbl[4]  = '{4'd6,  16'h8000, 16'h000F, pk(1,0,0,0,0,0,16'h0001)};
    tbl[5]  = '{4'd7,  16'h8000, 16'h000F, pk(1,0,1,0,0,0,16'hFFFF)};
    tbl[6]  = '{4'd12, 16'h1234, 16'hFFFF, pk(1,0,0,0,0,0,16'h1234)};
    tbl[7]  = '{4'd13, 16'h1234, 16'h0000, pk(1,1,0,0,0,0,16'h0000)};
    tbl[8]  = '{4'd15, 16'hFFFF, 16'hFFFF, pk(1,1,0,0,0,0,16'h0000)};
    tbl[9]  = '{4'd1,  16'h7FFF, 16'h0001, pk(1,0,1,0,1,0,16'h8000)};
    tbl[10] = '{4'd2,  16'h0001, 16'h0002, pk(1,0,1,0,0,0,16'hFFFF)};
    tbl[11] = '{4'd14, 16'h0001, 16'hFFFE, pk(1,1,0,0,0,0,16'h0000)};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 4'h0; a = '0; b = '0;
    tick();
    tick();
    chk("reset_outputs", obs(), pk(0,1,0,0,0,0,16'h0000));
    chk("reset_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    run_op(4'd1, 16'hFFFF, 16'h0001, lat);
    chk("add_wrap_lat", lat, 1);
    chk("add_wrap", obs(), pk(1,1,0,1,0,0,16'h0000));
    tick();
    chk("add_hold", obs(), pk(0,1,0,1,0,0,16'h0000));

    run_op(4'd2, 16'h8000, 16'h0001, lat);
    chk("sub_ovf", obs(), pk(1,0,0,1,1,0,16'h7FFF));
    run_op(4'd14, 16'hFFFE, 16'h0001, lat);
    chk("slt_neg", obs(), pk(1,0,0,1,0,0,16'h0001));
    tick();

    // Back-to-back single-cycle ops, one accepted per cycle
    foreach (tbl[i]) begin
      op = tbl[i].o; a = tbl[i].x; b = tbl[i].y; in_valid = 1'b1;
      tick();
      chk($sformatf("b2b_op%0d", tbl[i].o), obs(), tbl[i].e);
      chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();

    run_op(4'd8, 16'd300, 16'd300, lat);
    chk("mul_lat", lat, 16);
    chk("mul", obs(), pk(1,0,0,0,0,0,16'h5F90));
    chk("mul_ready_after", {31'b0, in_ready}, 32'd1);
    run_op(4'd9, 16'd300, 16'd300, lat);
    chk("mulhu_lat", lat, 16);
    chk("mulhu", obs(), pk(1,0,0,0,0,0,16'h0001));

    run_op(4'd10, 16'd1000, 16'd7, lat);
    chk("divu_lat", lat, 16);
    chk("divu", obs(), pk(1,0,0,0,0,0,16'd142));
    run_op(4'd11, 16'd1000, 16'd7, lat);
    chk("remu_lat", lat, 16);
    chk("remu", obs(), pk(1,0,0,0,0,0,16'd6));
    run_op(4'd10, 16'd5, 16'd0, lat);
    chk("divu_by0_lat", lat, 1);
    chk("divu_by0", obs(), pk(1,0,1,0,0,1,16'hFFFF));
    run_op(4'd11, 16'd5, 16'd0, lat);
    chk("remu_by0_lat", lat, 1);
    chk("remu_by0", obs(), pk(1,0,0,0,0,1,16'h0005));

    // Flush while idle blocks acceptance
    op = 4'd1; a = 16'd1; b = 16'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_blocks", obs(), pk(0,0,0,0,0,1,16'h0005));

    // Flush at iteration 5 of a MUL
    op = 4'd8; a = 16'd3; b = 16'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul_busy", {31'b0, in_ready}, 32'd0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_outputs", obs(), pk(0,0,0,0,0,1,16'h0005));
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);
    run_op(4'd1, 16'd2, 16'd3, lat);
    chk("add_after_flush_lat", lat, 1);
    chk("add_after_flush", obs(), pk(1,0,0,0,0,0,16'h0005));

    // Reset during DIVU iteration 8
    op = 4'd10; a = 16'd1000; b = 16'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_outputs", obs(), pk(0,1,0,0,0,0,16'h0000));
    chk("midreset_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midreset_no_valid", seen, 0);
    chk("midreset_hold", obs(), pk(0,1,0,0,0,0,16'h0000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
